// File: rtl/dotprod_pkg.sv
// Shared definitions for the dot-product engine: default widths and the
// one-hot FSM state encoding used by the top and visible on its debug port.
package dotprod_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 32;
  localparam int DEF_ACC_W = 2 * DEF_DW + 8;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

endpackage

// File: rtl/dotprod_mac.sv
// Two-stage multiply-accumulate: stage 1 registers the full-width product of the
// returned operands, stage 2 folds the (sign- or zero-extended) product into the sum.
module dotprod_mac
  import dotprod_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int ACC_W = 2 * DW + 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             mode_signed,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);

  localparam int PW  = 2 * DW;
  localparam int EXT = ACC_W - PW;

  logic signed [PW-1:0] a_s;
  logic signed [PW-1:0] b_s;
  logic signed [PW-1:0] prod_s;
  logic [PW-1:0]        prod_u;
  logic [PW-1:0]        prod_q;
  logic                 prod_vld;
  logic [ACC_W-1:0]     prod_ext;

  // Operands are widened to the product width first so the multiply is exact
  // in both modes; only the low PW bits are ever needed.
  assign a_s    = {{DW{a[DW-1]}}, a};
  assign b_s    = {{DW{b[DW-1]}}, b};
  assign prod_s = a_s * b_s;
  assign prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  assign prod_ext = {{EXT{mode_signed & prod_q[PW-1]}}, prod_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= in_valid;
      if (in_valid) begin
        prod_q <= mode_signed ? prod_s : prod_u;
      end
    end
  end

  // The sum wraps naturally at ACC_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (prod_vld) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/dotprod_pipe.sv
// Dot-product engine: streams indices 0..n-1 to two read ports, multiplies the
// returned elements pairwise and accumulates them into ap_return.
module dotprod_pipe
  import dotprod_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int MEM_LAT = 1,
  parameter int ACC_W   = 2 * DW + 8
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_idle,
  output logic               ap_ready,
  output logic               ap_done,
  input  logic [AW-1:0]      n,
  input  logic               mode_signed,
  output logic [AW-1:0]      a_address0,
  output logic               a_ce0,
  input  logic [DW-1:0]      a_q0,
  output logic [AW-1:0]      b_address0,
  output logic               b_ce0,
  input  logic [DW-1:0]      b_q0,
  output logic [ACC_W-1:0]   ap_return,
  output logic [STATE_W-1:0] dbg_state
);

  // Handshake: ap_start is accepted only in a cycle where ap_idle=1. ap_ready
  // pulses in the cycle the last index is issued (the start cycle when n=0),
  // ap_done pulses for one cycle while ap_return carries the result, and
  // ap_return then holds until the next operation completes.

  state_e           state;
  state_e           state_nxt;
  logic [AW-1:0]    n_q;
  logic             mode_q;
  logic [AW-1:0]    idx;
  logic [2:0]       drain_cnt;
  logic [MEM_LAT-1:0] vld_sr;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ret_q;
  logic             start_ok;
  logic             last_issue;
  logic             drain_last;

  assign start_ok   = (state == S_IDLE) && ap_start;
  assign last_issue = (state == S_ISSUE) && (idx == n_q - 1'b1);
  assign drain_last = (state == S_DRAIN) && (drain_cnt == 3'(MEM_LAT));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start) state_nxt = (n == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      n_q    <= '0;
      mode_q <= 1'b0;
    end else if (start_ok) begin
      n_q    <= n;
      mode_q <= mode_signed;
    end
  end

  // idx sits at 0 outside ISSUE so the issued address is 0 on the first beat.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      idx <= '0;
    end else if (state == S_ISSUE && !last_issue) begin
      idx <= idx + 1'b1;
    end else begin
      idx <= '0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)                 drain_cnt <= '0;
    else if (state == S_DRAIN)  drain_cnt <= drain_cnt + 3'd1;
    else                        drain_cnt <= '0;
  end

  // Issue strobe delayed to line up with the memory's returned data.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= (state == S_ISSUE);
      for (int k = 1; k < MEM_LAT; k++) begin
        vld_sr[k] <= vld_sr[k-1];
      end
    end
  end

  dotprod_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk         (ap_clk),
    .rst         (ap_rst),
    .clear       (start_ok),
    .in_valid    (vld_sr[MEM_LAT-1]),
    .mode_signed (mode_q),
    .a           (a_q0),
    .b           (b_q0),
    .acc         (acc)
  );

  // The final sum settles on entry to DONE; keep a copy for the idle period.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)                ret_q <= '0;
    else if (state == S_DONE)  ret_q <= acc;
  end

  assign ap_return  = (state == S_DONE) ? acc : ret_q;
  assign ap_idle    = (state == S_IDLE);
  assign ap_done    = (state == S_DONE);
  assign ap_ready   = last_issue || (start_ok && (n == '0));
  assign a_ce0      = (state == S_ISSUE);
  assign b_ce0      = (state == S_ISSUE);
  assign a_address0 = (state == S_ISSUE) ? idx : '0;
  assign b_address0 = (state == S_ISSUE) ? idx : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_dotprod_pipe.sv
// Bench for dotprod_pipe: an 8-bit/latency-1 instance and a 32-bit/latency-3
// instance, each fed from a small memory model and checked against a reference sum.
module tb_dotprod_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_a, start_b;
  logic [7:0] n;
  logic       mode;

  logic        idle_a, ready_a, done_a, ace_a, bce_a;
  logic [7:0]  aaddr_a, baddr_a, aq_a, bq_a;
  logic [23:0] ret_a;
  logic [3:0]  st_a;

  logic        idle_b, ready_b, done_b, ace_b, bce_b;
  logic [7:0]  aaddr_b, baddr_b;
  logic [31:0] aq_b, bq_b;
  logic [71:0] ret_b;
  logic [3:0]  st_b;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [7:0]  rda_a;
  logic [7:0]  rdb_a;
  logic [31:0] rda_b [3];
  logic [31:0] rdb_b [3];

  int n_checks = 0;
  int n_errors = 0;

  dotprod_pipe #(.DW(8), .AW(8), .MEM_LAT(1), .ACC_W(24)) u_dut_a (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_a), .ap_idle(idle_a),
    .ap_ready(ready_a), .ap_done(done_a), .n(n), .mode_signed(mode),
    .a_address0(aaddr_a), .a_ce0(ace_a), .a_q0(aq_a),
    .b_address0(baddr_a), .b_ce0(bce_a), .b_q0(bq_a),
    .ap_return(ret_a), .dbg_state(st_a)
  );

  dotprod_pipe #(.DW(32), .AW(8), .MEM_LAT(3), .ACC_W(72)) u_dut_b (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_b), .ap_idle(idle_b),
    .ap_ready(ready_b), .ap_done(done_b), .n(n), .mode_signed(mode),
    .a_address0(aaddr_b), .a_ce0(ace_b), .a_q0(aq_b),
    .b_address0(baddr_b), .b_ce0(bce_b), .b_q0(bq_b),
    .ap_return(ret_b), .dbg_state(st_b)
  );

  // Memory models: data for an address read in cycle c appears in cycle c+latency.
  always @(posedge clk) begin
    rda_a <= ace_a ? mem_a[aaddr_a[3:0]][7:0] : 8'h00;
    rdb_a <= bce_a ? mem_b[baddr_a[3:0]][7:0] : 8'h00;
    rda_b[0] <= ace_b ? mem_a[aaddr_b[3:0]] : 32'h0;
    rdb_b[0] <= bce_b ? mem_b[baddr_b[3:0]] : 32'h0;
    rda_b[1] <= rda_b[0];
    rdb_b[1] <= rdb_b[0];
    rda_b[2] <= rda_b[1];
    rdb_b[2] <= rdb_b[1];
  end
  assign aq_a = rda_a;
  assign bq_a = rdb_a;
  assign aq_b = rda_b[2];
  assign bq_b = rdb_b[2];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mathematical dot product of the first cnt elements, reduced modulo 2^accw.
  function automatic logic [71:0] ref_dot(int cnt, bit sgn, int dw, int accw);
    logic [71:0] acc, x, y, msk;
    acc = '0;
    msk = (dw == 8) ? 72'hFF : 72'hFFFF_FFFF;
    for (int i = 0; i < cnt; i++) begin
      x = {40'b0, mem_a[i]} & msk;
      y = {40'b0, mem_b[i]} & msk;
      if (sgn && x[dw-1]) x = x - (msk + 72'd1);
      if (sgn && y[dw-1]) y = y - (msk + 72'd1);
      acc = acc + x * y;
    end
    if (accw < 72) acc = acc & ((72'd1 << accw) - 72'd1);
    return acc;
  endfunction

  function automatic logic obs_idle(int sel);  return sel != 0 ? idle_b : idle_a;   endfunction
  function automatic logic obs_ready(int sel); return sel != 0 ? ready_b : ready_a; endfunction
  function automatic logic obs_done(int sel);  return sel != 0 ? done_b : done_a;   endfunction
  function automatic logic [71:0] obs_ret(int sel);
    return sel != 0 ? ret_b : {48'b0, ret_a};
  endfunction

  // Counts cycles where either port's enable/address differs from the expected pattern.
  function automatic int port_bad(int sel, bit exp_ce, int exp_addr);
    logic [7:0] ea;
    ea = 8'(exp_addr);
    if (sel != 0)
      return (ace_b !== exp_ce || bce_b !== exp_ce || aaddr_b !== ea || baddr_b !== ea) ? 1 : 0;
    return (ace_a !== exp_ce || bce_a !== exp_ce || aaddr_a !== ea || baddr_a !== ea) ? 1 : 0;
  endfunction

  task automatic set_start(int sel, logic v);
    if (sel != 0) start_b = v;
    else          start_a = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = $urandom();
      mem_b[i] = $urandom();
    end
  endtask

  task automatic run_op(input int sel, input int cnt, input bit sgn, input bit hold,
                        input bit chained, output logic [71:0] res);
    int ml, dw, accw, done_cyc, ready_cyc, ready_cnt, bad, exp_done, exp_ready;
    logic [71:0] exp;
    ml   = (sel != 0) ? 3 : 1;
    dw   = (sel != 0) ? 32 : 8;
    accw = (sel != 0) ? 72 : 24;
    exp  = ref_dot(cnt, sgn, dw, accw);
    exp_done  = (cnt == 0) ? 1 : cnt + ml + 2;
    exp_ready = (cnt == 0) ? 0 : cnt;
    res = '0;
    if (chained) begin
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
    end
    n = 8'(cnt);
    mode = sgn;
    set_start(sel, 1'b1);
    #1;
    check("idle_at_start", 72'(obs_idle(sel)), 72'd1);
    ready_cyc = -1; ready_cnt = 0; done_cyc = -1; bad = 0;
    if (obs_ready(sel)) begin ready_cyc = 0; ready_cnt++; end
    bad += port_bad(sel, 1'b0, 0);
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (!hold) set_start(sel, 1'b0);
      n = 8'($urandom_range(0, 255));
      mode = 1'($urandom_range(0, 1));
      bad += port_bad(sel, cyc <= cnt, (cyc <= cnt) ? cyc - 1 : 0);
      if (obs_ready(sel)) begin ready_cyc = cyc; ready_cnt++; end
      if (obs_done(sel)) begin done_cyc = cyc; res = obs_ret(sel); end
    end
    check("done_cycle", 72'(done_cyc), 72'(exp_done));
    check("ready_cycle", 72'(ready_cyc), 72'(exp_ready));
    check("ready_pulses", 72'(ready_cnt), 72'd1);
    check("ce_addr_pattern", 72'(bad), 72'd0);
    check("result", res, exp);
    if (!hold) begin
      @(posedge clk); #1;
      check("done_one_cycle", 72'(obs_done(sel)), 72'd0);
      check("idle_after_done", 72'(obs_idle(sel)), 72'd1);
      repeat (3) @(posedge clk);
      #1;
      check("return_hold", obs_ret(sel), exp);
    end
  endtask

  logic [71:0] res;
  int done_seen;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; n = '0; mode = 1'b0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", 72'(idle_a), 72'd1);
    check("rst_ce", 72'({ace_a, bce_a, ace_b, bce_b}), 72'd0);
    check("rst_return", {48'b0, ret_a} | ret_b, 72'd0);
    check("rst_state", 72'(st_a), 72'd1);
    @(negedge clk);
    rst = 1'b0;

    // Small unsigned vector.
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
    mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
    run_op(0, 4, 1'b0, 1'b0, 1'b0, res);
    check("basic_70", res, 72'd70);

    // Same 8-bit data in signed and unsigned mode.
    mem_a[0] = 32'hFD; mem_a[1] = 32'h7F; mem_b[0] = 32'h04; mem_b[1] = 32'h80;
    run_op(0, 2, 1'b1, 1'b0, 1'b0, res);
    check("signed_neg", res, 72'hFF_C074);
    run_op(0, 2, 1'b0, 1'b0, 1'b0, res);
    check("unsigned_17268", res, 72'd17268);

    // Empty vector.
    run_op(0, 0, 1'b0, 1'b0, 1'b0, res);
    check("empty_zero", res, 72'd0);

    // Back-to-back with start held; fresh data for the second run.
    fill_random();
    run_op(0, 3, 1'b0, 1'b1, 1'b0, res);
    fill_random();
    run_op(0, 3, 1'b1, 1'b0, 1'b1, res);

    // Reset in the middle of issuing.
    fill_random();
    @(negedge clk);
    n = 8'd8; mode = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_addr_2", 72'(aaddr_a), 72'd2);
    rst = 1'b1;
    #1;
    check("rst_mid_ce", 72'({ace_a, bce_a}), 72'd0);
    check("rst_mid_addr", 72'({aaddr_a, baddr_a}), 72'd0);
    check("rst_mid_flags", 72'({idle_a, ready_a, done_a}), 72'b100);
    check("rst_mid_return", 72'(ret_a), 72'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_a) done_seen++;
    end
    check("no_done_after_rst", 72'(done_seen), 72'd0);
    mem_a[0] = 2; mem_b[0] = 2;
    run_op(0, 1, 1'b0, 1'b0, 1'b0, res);
    check("after_rst_4", res, 72'd4);

    // Wide instance, all-ones operands.
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'hFFFF_FFFF;
      mem_b[i] = 32'hFFFF_FFFF;
    end
    run_op(1, 2, 1'b0, 1'b0, 1'b0, res);
    check("wide_allones", res, 72'h1_FFFF_FFFC_0000_0002);

    // Random operations on both instances.
    for (int k = 0; k < 16; k++) begin
      fill_random();
      run_op(k % 2, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, res);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dotprod_pipe.md
DOTPROD_PIPE -- requirements
Module: dotprod_pipe

Interface
REQ-001 Parameter DW, default 32: element width of a_q0/b_q0.
REQ-002 Parameter AW, default 32: address and length width.
REQ-003 Parameter MEM_LAT, default 1, range 1..4: memory read latency in cycles from ce/address to q.
REQ-004 Parameter ACC_W, default 2*DW+8: accumulator and result width.
REQ-005 Port ap_clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-006 Port ap_rst, input, 1: asynchronous, active-high reset.
REQ-007 Port ap_start, input, 1: request to begin an operation.
REQ-008 Port ap_idle, output, 1: block is in IDLE.
REQ-009 Port ap_ready, output, 1: one-cycle pulse when the last address is issued.
REQ-010 Port ap_done, output, 1: one-cycle pulse when ap_return is valid.
REQ-011 Port n, input, AW: vector length, sampled at start.
REQ-012 Port mode_signed, input, 1: 1 = two's-complement operands, 0 = unsigned; sampled at start.
REQ-013 Ports a_address0 and b_address0, output, AW: element index.
REQ-014 Ports a_ce0 and b_ce0, output, 1: read enables.
REQ-015 Ports a_q0 and b_q0, input, DW: read data, valid MEM_LAT cycles after ce.
REQ-016 Port ap_return, output, ACC_W: dot product result.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE, encoded one-hot.
REQ-018 IDLE: ap_idle=1; on ap_start=1, latch n and mode_signed, clear the accumulator, and go to ISSUE if n!=0, else to DONE.
REQ-019 ISSUE: assert a_ce0=b_ce0=1 with address i=0..n-1 (one per cycle, both ports identical); after i=n-1 go to DRAIN.
- ap_ready=1 during the cycle that issues i=n-1.
- For n=0, ap_ready pulses in the IDLE start cycle.
REQ-020 DRAIN: remain MEM_LAT+1 cycles until the final product is accumulated, then go to DONE.
REQ-021 Datapath is a 2-stage pipeline:
- Stage 1: q data × q data into a registered 2*DW product, sign- or zero-extended per the latched mode.
- Stage 2: the product is added to ACC_W accumulator.
- A valid bit SHALL be delayed MEM_LAT cycles alongside the read.
REQ-022 Accumulation SHALL wrap modulo 2^ACC_W; there is no saturation and no overflow flag.
REQ-023 DONE: ap_done=1 for exactly one cycle; ap_return=accumulator; next state IDLE.
REQ-024 ap_return SHALL hold its value until the next ap_start is accepted.
REQ-025 Latency from the ap_start sample cycle (cycle 0) SHALL be:
- ap_done at cycle n+MEM_LAT+2 for n>=1;
- ap_done at cycle 1 for n=0.
REQ-026 ap_start is ignored outside IDLE; changes to n and mode_signed mid-operation SHALL have no effect.
REQ-027 If ap_start is held high, the next operation SHALL be accepted in the IDLE cycle immediately following DONE.
REQ-028 ce SHALL be 0 and addresses SHALL hold 0 in every state except ISSUE.

Reset
REQ-029 On ap_rst=1, asynchronously: FSM to IDLE, accumulator, pipeline valids, ap_return, addresses and ce to 0, ap_ready=ap_done=0, ap_idle=1.
REQ-030 Reset mid-operation SHALL abandon the operation with no ap_done pulse; in-flight memory data returning after reset SHALL be ignored.

Structure
REQ-031 The shared package SHALL hold the one-hot state encoding constants and the default DW/AW/ACC_W values.
REQ-032 Sub-module dotprod_mac: stage-1 multiply plus stage-2 accumulate, with clear, valid and mode inputs; the top holds the FSM and address counter.

Verification
REQ-033 Unsigned, n=4, a={1,2,3,4}, b={5,6,7,8}, MEM_LAT=1 -> ap_return=70, ap_done at cycle 7, ap_ready at cycle 4.
REQ-034 Signed, DW=8, n=2, a={-3,127}, b={4,-128} -> ap_return=-16268 sign-extended to ACC_W; the same data unsigned -> 253*4+127*128=17268.
REQ-035 n=0 -> ap_done at cycle 1, ap_return=0, ce never asserted.
REQ-036 ap_start held high across two n=3 operations -> second ap_idle/accept in the cycle after the first ap_done, and results are independent (accumulator cleared).
REQ-037 Assert ap_rst during ISSUE at i=2 of n=8 -> all outputs reset within the same cycle, no ap_done; a subsequent n=1, a=b=2 run -> 4.
REQ-038 MEM_LAT=3, DW=32, n=2, all operands 0xFFFFFFFF unsigned, ACC_W=72 -> ap_return=2*(2^32-1)^2, ap_done at cycle 7.
